// File: rtl/spi_sync_edge.sv
// Purpose: multi-stage synchroniser for one asynchronous pin plus a rise/fall pulse detector.
// Latency: o_rise/o_fall assert SYNC_STAGES cycles after the pin changes and last one cycle.
// Backpressure: none; every edge that survives synchronisation produces exactly one pulse.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Shift the pin through the synchroniser chain and keep one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;
    assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Purpose: SPI mode-0 responder, MSB first, one RX and one TX holding byte towards the CPU.
// Latency: pin to action SYNC_STAGES+1 clk; rx_full/dout one clk after the completing sck rise.
// Backpressure: none on SPI; an unread RX byte causes the next one to be dropped with overrun.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_di,
    output logic       spi_do,
    output logic       spi_do_oe,
    input  logic [7:0] din,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic [7:0] dout,
    output logic       rx_full,
    input  logic       rx_read,
    output logic       overrun,
    output logic       busy
);

    localparam int BITCNT_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [BITCNT_W-1:0]   r_bitcnt;
    logic                  r_reload;
    logic [7:0]            r_tx_shift;
    logic [7:0]            r_tx_hold;
    logic                  r_tx_empty;
    logic [7:0]            r_rx_shift;
    logic [7:0]            r_dout;
    logic                  r_rx_full;
    logic                  r_overrun;
    logic                  r_busy;
    logic                  r_oe;
    logic [SYNC_STAGES-1:0] r_di_sync;

    logic       w_cs_rise;
    logic       w_cs_fall;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_di_s;
    logic       w_reload;
    logic [7:0] w_tx_next;
    logic [7:0] w_rx_byte;

    // Chip select chain resets to "selected": a cs_n still held low across reset then
    // shows no falling edge, so no frame starts until the master releases and reasserts it.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi_clk),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    // MOSI needs the same depth as SCK so the sampled bit lines up with the detected rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_di_sync <= '0;
        end else begin
            r_di_sync[0] <= spi_di;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_di_sync[i] <= r_di_sync[i-1];
            end
        end
    end

    assign w_di_s    = r_di_sync[SYNC_STAGES-1];
    assign w_rx_byte = {r_rx_shift[6:0], w_di_s};

    // Decide when the TX shift register takes a fresh byte and which byte that is;
    // a CPU write landing on the reload cycle goes straight into the shifter if the holder is free.
    always_comb begin
        w_reload  = 1'b0;
        w_tx_next = IDLE_BYTE;
        if (r_state == ST_IDLE) begin
            w_reload = w_cs_fall;
        end else begin
            w_reload = !w_cs_rise && w_sck_fall && r_reload;
        end
        if (!r_tx_empty) begin
            w_tx_next = r_tx_hold;
        end else if (tx_load) begin
            w_tx_next = din;
        end
    end

    // Frame state machine, shifters and CPU-side flags, all in one registered block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= '0;
            r_reload   <= 1'b0;
            r_tx_shift <= 8'hFF;
            r_tx_hold  <= 8'h00;
            r_tx_empty <= 1'b1;
            r_rx_shift <= 8'h00;
            r_dout     <= 8'h00;
            r_rx_full  <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            if (rx_read) begin
                r_rx_full <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (tx_load) begin
                r_tx_hold  <= din;
                r_tx_empty <= 1'b0;
            end

            // Holder stays occupied only if it was full and the CPU refilled it this cycle.
            if (w_reload) begin
                r_tx_shift <= w_tx_next;
                r_tx_empty <= r_tx_empty || !tx_load;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state  <= ST_SHIFT;
                        r_busy   <= 1'b1;
                        r_oe     <= 1'b1;
                        r_bitcnt <= '0;
                        r_reload <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        // Partial byte is simply abandoned; nothing reaches the CPU side.
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_oe     <= 1'b0;
                        r_bitcnt <= '0;
                        r_reload <= 1'b0;
                    end else begin
                        if (w_sck_rise) begin
                            r_rx_shift <= w_rx_byte;
                            r_bitcnt   <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 3'd7) begin
                                r_reload <= 1'b1;
                                if (!r_rx_full || rx_read) begin
                                    r_dout    <= w_rx_byte;
                                    r_rx_full <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                        if (w_sck_fall) begin
                            if (r_reload) begin
                                r_reload <= 1'b0;
                            end else begin
                                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spi_do    = r_tx_shift[7];
    assign spi_do_oe = r_oe;
    assign tx_empty  = r_tx_empty;
    assign dout      = r_dout;
    assign rx_full   = r_rx_full;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 responder for the Spectrum core: lets an external SPI master (e.g. a companion MCU) exchange bytes with the CPU side of the design. All SPI pins are sampled and synchronised into the `clk` domain; no logic runs on the SPI clock. MSB first on both lines, with a single-byte receive holding register and a single-byte transmit holding register on the CPU side.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages per synchroniser on `spi_cs_n`, `spi_clk` and `spi_di`.
- `IDLE_BYTE`, 8'hFF: byte shifted out when no CPU byte is pending.

- `clk`  in  1  system clock. One clock only.
- `rst`  in  1  synchronous, active-high reset.
- `spi_cs_n`  in  1  chip select from the master, active low.
- `spi_clk`  in  1  SPI clock from the master. Idle low; sample on rising edge.
- `spi_di`  in  1  MOSI.
- `spi_do`  out  1  MISO data.
- `spi_do_oe`  out  1  MISO output enable; 1 only while the block is selected.
- `din`  in  8  byte from the CPU to send.
- `tx_load`  in  1  one-cycle strobe; writes `din` into the TX holding register.
- `tx_empty`  out  1  1 = TX holding register free.
- `dout`  out  8  last complete received byte.
- `rx_full`  out  1  1 = `dout` holds an unread byte.
- `rx_read`  in  1  one-cycle strobe; CPU consumed `dout`. Clears `rx_full` and `overrun`.
- `overrun`  out  1  sticky. A byte completed while `rx_full` was 1.
- `busy`  out  1  1 = chip select asserted (frame in progress).

## Operation
- Synchronised signals are `cs_s`, `sck_s` and `di_s`. Edge detection uses a further register stage on each: `cs_fall`, `cs_rise`, `sck_rise`, `sck_fall`.
- States:
  - IDLE: `cs_s` = 1.
  - SHIFT: `cs_s` = 0.
  - IDLE→SHIFT on `cs_fall`. SHIFT→IDLE on `cs_rise`.
- On `cs_fall`:
  - `bitcnt` ← 0.
  - TX shift register loads from the holding register if `tx_empty` = 0, otherwise from `IDLE_BYTE`.
  - On a load from the holding register, `tx_empty` ← 1.
  - `spi_do` = TX shift register bit 7.
- On `sck_rise` in SHIFT:
  - RX shift ← {rx_shift[6:0], di_s}.
  - `bitcnt` increments (3 bits, wraps 7→0).
  - On the wrap the byte is complete. If `rx_full` = 0: `dout` ← new byte, `rx_full` ← 1. If `rx_full` = 1: `dout` unchanged, byte dropped, `overrun` ← 1.
  - Set `reload` flag on the wrap.
- On `sck_fall` in SHIFT:
  - If `reload` = 1: reload the TX shift register using the same rule as `cs_fall`, then clear `reload`.
  - Otherwise: TX shift ← {tx_shift[6:0], 1'b1}.
- `cs_rise` mid-byte: the partial RX byte is discarded, with no `rx_full` and no `overrun`. A TX byte already moved into the shift register is lost. The holding register is untouched.
- Simultaneous events:
  - `tx_load` in the same cycle as a TX reload: `din` bypasses into the shift register and `tx_empty` stays 1.
  - `tx_load` while `tx_empty` = 0 (and no reload): `din` overwrites the holding register.
  - `rx_read` in the same cycle as byte completion: the new byte is stored, `rx_full` stays 1, `overrun` is not set.

## Timing
- Reset values:
  - `spi_do` = 1, `spi_do_oe` = 0, `dout` = 8'h00.
  - `rx_full` = 0, `overrun` = 0, `tx_empty` = 1, `busy` = 0.
  - Internal: `bitcnt` = 0, `reload` = 0.
- Reset mid-frame aborts the frame. The block waits for the next `cs_fall`; a still-low `cs_n` after reset does not start a frame.
- Input-pin to edge-detect latency is `SYNC_STAGES`+1 cycles.
- `spi_clk` high and low phases must each be ≥ `SYNC_STAGES`+2 clk periods. With defaults, f_sck ≤ f_clk/8.
- `rx_full` rises one cycle after the `sck_rise` that completes the byte. It is registered, and `dout` is valid in the same cycle.
- `spi_do` changes one cycle after `sck_fall` or `cs_fall`.
- `spi_do_oe` = ~`cs_s`, registered.
- `busy` = ~`cs_s`, registered.

## Structure
- No shared package is needed. Local parameters for bit count width (3) and the IDLE/SHIFT state encoding stay in the module.
- One natural sub-module: `spi_sync_edge`. It is a SYNC_STAGES-deep synchroniser plus a rise/fall detector, instantiated for `spi_cs_n` and `spi_clk`. `spi_di` uses the synchroniser only.

## Test plan
- Load `din` = 8'hA5 with `tx_load`, then the master clocks 8'h3C at clk/8 → MISO bits 1,0,1,0,0,1,0,1 and `tx_empty` = 1 after `cs_fall`; `dout` = 8'h3C with `rx_full` = 1 after the 8th rising edge.
- No `tx_load`, 2-byte frame → MISO reads 8'hFF, 8'hFF.
- Two bytes 8'h11, 8'h22 with no `rx_read` between → `dout` = 8'h11 and `overrun` = 1. A following `rx_read` clears both flags.
- `cs_n` deasserted after 5 bits, then a new frame sending 8'h81 → `dout` = 8'h81 only, with no spurious `rx_full` from the partial byte.
- `tx_load` of 8'h5A coincident with the reload `sck_fall` of byte 2 → the second MISO byte = 8'h5A and `tx_empty` = 1.
- `rst` asserted mid-byte with `cs_n` held low → all outputs at reset values; no byte is received until `cs_n` goes high then low again.
